// File: rtl/sd_sector_responder_if.sv
// Block-transfer bundle between the core disk controller, the sector responder and the image memory port.
// The responder takes the slave modport; the core/memory side takes master.
interface sd_sector_responder_if #(
    parameter int ADDR_W = 24
);
    logic [31:0]       sd_lba;
    logic [1:0]        sd_rd;
    logic [1:0]        sd_wr;
    logic              sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic              sd_buff_wr;
    logic [7:0]        sd_buff_din;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_dout;
    logic [7:0]        mem_din;
    logic              mem_ready;

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_din, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_dout
    );

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_din, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_dout
    );
endinterface

// File: rtl/sd_sector_responder.sv
// Answers 512-byte sector requests for two drive images from a byte-wide memory port.
// Define SD_RESP_WRITE_EN to let write transfers reach memory; otherwise images are write-protected.
//
// state     | meaning
// IDLE      | waiting for a read/write request
// RD_MEM    | memory read in flight for byte idx
// RD_PUT    | strobing byte idx into the core buffer
// WR_ADDR   | presenting idx to the core buffer
// WR_CAP    | capturing core buffer byte
// WR_MEM    | memory write in flight for byte idx
// DONE      | ack dropped for one cycle
module sd_sector_responder #(
    parameter int                ADDR_W      = 24,
    parameter int                MAX_SECTORS = 1600,
    parameter logic [ADDR_W-1:0] DRIVE1_BASE = 24'h100000,
    parameter logic [7:0]        FILL_BYTE   = 8'hE5
) (
    input logic                  clk_sys,
    input logic                  reset,
    sd_sector_responder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_MEM, S_RD_PUT, S_WR_ADDR, S_WR_CAP, S_WR_MEM, S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [31:0]       lba_q, lba_nx;
    logic              drive_q, drive_nx;
    logic              oor_q, oor_nx;
    logic [8:0]        idx, idx_nx;
    logic              ack_q, ack_nx;
    logic [8:0]        buff_addr_q, buff_addr_nx;
    logic [7:0]        buff_dout_q, buff_dout_nx;
    logic              buff_wr_q, buff_wr_nx;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_nx;
    logic              mem_rd_q, mem_rd_nx;
    logic              mem_wr_q, mem_wr_nx;
    logic [7:0]        mem_dout_q, mem_dout_nx;
    logic              wr_step;
    logic              last;
    logic              req_oor;
    logic [8:0]        idx_inc;

    function automatic logic [ADDR_W-1:0] byte_addr(input logic [31:0] l, input logic d,
                                                    input logic [8:0] i);
        return ADDR_W'({l, i}) + (d ? DRIVE1_BASE : '0);
    endfunction

    assign last    = (idx == 9'd511);
    assign idx_inc = idx + 9'd1;
    assign req_oor = (bus.sd_lba >= 32'(MAX_SECTORS));

    always_comb begin
        state_nx     = state;
        lba_nx       = lba_q;
        drive_nx     = drive_q;
        oor_nx       = oor_q;
        idx_nx       = idx;
        ack_nx       = ack_q;
        buff_addr_nx = buff_addr_q;
        buff_dout_nx = buff_dout_q;
        buff_wr_nx   = 1'b0;
        mem_addr_nx  = mem_addr_q;
        mem_rd_nx    = mem_rd_q;
        mem_wr_nx    = mem_wr_q;
        mem_dout_nx  = mem_dout_q;
        wr_step      = 1'b0;

        case (state)
            S_IDLE: begin
                if (|bus.sd_rd || |bus.sd_wr) begin
                    ack_nx       = 1'b1;
                    lba_nx       = bus.sd_lba;
                    oor_nx       = req_oor;
                    idx_nx       = 9'd0;
                    buff_addr_nx = 9'd0;
                    if (|bus.sd_rd) begin
                        drive_nx = ~bus.sd_rd[0];
                        if (req_oor) begin
                            state_nx     = S_RD_PUT;
                            buff_wr_nx   = 1'b1;
                            buff_dout_nx = FILL_BYTE;
                        end else begin
                            state_nx    = S_RD_MEM;
                            mem_rd_nx   = 1'b1;
                            mem_addr_nx = byte_addr(bus.sd_lba, ~bus.sd_rd[0], 9'd0);
                        end
                    end else begin
                        drive_nx = ~bus.sd_wr[0];
                        state_nx = S_WR_ADDR;
                    end
                end
            end
            S_RD_MEM: begin
                if (bus.mem_ready) begin
                    state_nx     = S_RD_PUT;
                    mem_rd_nx    = 1'b0;
                    buff_wr_nx   = 1'b1;
                    buff_addr_nx = idx;
                    buff_dout_nx = bus.mem_din;
                end
            end
            S_RD_PUT: begin
                if (last) begin
                    state_nx = S_DONE;
                    ack_nx   = 1'b0;
                end else begin
                    idx_nx = idx_inc;
                    if (oor_q) begin
                        buff_wr_nx   = 1'b1;
                        buff_addr_nx = idx_inc;
                        buff_dout_nx = FILL_BYTE;
                    end else begin
                        state_nx    = S_RD_MEM;
                        mem_rd_nx   = 1'b1;
                        mem_addr_nx = byte_addr(lba_q, drive_q, idx_inc);
                    end
                end
            end
            S_WR_ADDR: state_nx = S_WR_CAP;
            S_WR_CAP: begin
`ifdef SD_RESP_WRITE_EN
                if (!oor_q) begin
                    state_nx    = S_WR_MEM;
                    mem_wr_nx   = 1'b1;
                    mem_dout_nx = bus.sd_buff_din;
                    mem_addr_nx = byte_addr(lba_q, drive_q, idx);
                end else begin
                    wr_step = 1'b1;
                end
`else
                wr_step = 1'b1;
`endif
            end
            S_WR_MEM: begin
                if (bus.mem_ready) begin
                    mem_wr_nx = 1'b0;
                    wr_step   = 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // Shared byte advance for the write path, whether or not memory was touched.
        if (wr_step) begin
            if (last) begin
                state_nx = S_DONE;
                ack_nx   = 1'b0;
            end else begin
                state_nx     = S_WR_ADDR;
                idx_nx       = idx_inc;
                buff_addr_nx = idx_inc;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            lba_q       <= '0;
            drive_q     <= 1'b0;
            oor_q       <= 1'b0;
            idx         <= '0;
            ack_q       <= 1'b0;
            buff_addr_q <= '0;
            buff_dout_q <= '0;
            buff_wr_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_dout_q  <= '0;
        end else begin
            state       <= state_nx;
            lba_q       <= lba_nx;
            drive_q     <= drive_nx;
            oor_q       <= oor_nx;
            idx         <= idx_nx;
            ack_q       <= ack_nx;
            buff_addr_q <= buff_addr_nx;
            buff_dout_q <= buff_dout_nx;
            buff_wr_q   <= buff_wr_nx;
            mem_addr_q  <= mem_addr_nx;
            mem_rd_q    <= mem_rd_nx;
            mem_wr_q    <= mem_wr_nx;
            mem_dout_q  <= mem_dout_nx;
        end
    end

    assign bus.sd_ack       = ack_q;
    assign bus.sd_buff_addr = buff_addr_q;
    assign bus.sd_buff_dout = buff_dout_q;
    assign bus.sd_buff_wr   = buff_wr_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_rd       = mem_rd_q;
    assign bus.mem_wr       = mem_wr_q;
    assign bus.mem_dout     = mem_dout_q;
endmodule

// File: tb/tb_sd_sector_responder.sv
// Randomized bench for sd_sector_responder: core buffer and image memory models plus a
// transfer-level reference of which bytes should move where.
`timescale 1ns/1ps
module tb_sd_sector_responder;
    localparam int MAXS = 1600;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    sd_sector_responder_if #(.ADDR_W(24)) bus();

    sd_sector_responder dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [16:0] strobe_q[$];
    logic [23:0] rd_q[$];
    logic [31:0] wr_q[$];
    logic [7:0]  core_buf[512];
    int          max_delay = 0;
    int          hold_err = 0;
    int          both_err = 0;

    logic        mbusy = 1'b0;
    int          mwait = 0;
    logic [23:0] mheld_addr;
    logic        mheld_rd;
    logic [8:0]  core_a;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    function automatic logic [23:0] exp_addr(input int drive, input logic [31:0] lba, input int i);
        longint a;
        a = (drive != 0 ? 64'h100000 : 64'h0) + longint'(lba) * 512 + i;
        return a[23:0];
    endfunction

    // Strobe monitor
    initial forever begin
        @(negedge clk_sys);
        if (!reset) begin
            if (bus.sd_buff_wr) strobe_q.push_back({bus.sd_buff_addr, bus.sd_buff_dout});
            if (bus.mem_rd && bus.mem_wr) both_err++;
        end
    end

    // Image memory with random completion delay
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_din   = 8'h00;
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                mbusy = 1'b0;
                bus.mem_ready = 1'b0;
            end else if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
            end else begin
                if (mbusy && (!(bus.mem_rd || bus.mem_wr) || bus.mem_addr != mheld_addr
                              || bus.mem_rd != mheld_rd))
                    hold_err++;
                if (!mbusy && (bus.mem_rd || bus.mem_wr)) begin
                    mbusy      = 1'b1;
                    mwait      = int'($urandom_range(max_delay, 0));
                    mheld_addr = bus.mem_addr;
                    mheld_rd   = bus.mem_rd;
                end
                if (mbusy) begin
                    if (mwait == 0) begin
                        mbusy = 1'b0;
                        bus.mem_ready = 1'b1;
                        if (mheld_rd) begin
                            rd_q.push_back(mheld_addr);
                            bus.mem_din = mem_byte(mheld_addr);
                        end else begin
                            wr_q.push_back({mheld_addr, bus.mem_dout});
                        end
                    end else begin
                        mwait--;
                    end
                end
            end
        end
    end

    // Core buffer: data appears one cycle after the address
    initial begin
        bus.sd_buff_din = 8'h00;
        forever begin
            @(negedge clk_sys);
            core_a = bus.sd_buff_addr;
            @(posedge clk_sys);
            #1 bus.sd_buff_din = core_buf[core_a];
        end
    end

    task automatic run_xfer(input string name, input logic [1:0] rd, input logic [1:0] wr,
                            input logic [31:0] lba);
        int  drive;
        bit  is_rd;
        bit  oor;
        int  cyc;
        int  n_exp;
        if (rd[0])      begin drive = 0; is_rd = 1; end
        else if (rd[1]) begin drive = 1; is_rd = 1; end
        else if (wr[0]) begin drive = 0; is_rd = 0; end
        else            begin drive = 1; is_rd = 0; end
        oor = (lba >= 32'(MAXS));
        for (int i = 0; i < 512; i++) core_buf[i] = 8'($urandom);

        repeat (2) @(negedge clk_sys);
        strobe_q.delete();
        rd_q.delete();
        wr_q.delete();
        bus.sd_lba = lba;
        bus.sd_rd  = rd;
        bus.sd_wr  = wr;
        @(posedge clk_sys);
        #1;
        check({name, ".ack_latency"}, 64'(bus.sd_ack), 64'd1);
        bus.sd_rd  = 2'b00;
        bus.sd_wr  = 2'b00;
        bus.sd_lba = $urandom;
        cyc = 0;
        while (bus.sd_ack && cyc < 20000) begin
            @(posedge clk_sys);
            #1;
            cyc++;
        end
        check({name, ".ack_drop_in_time"}, 64'(cyc < 20000), 64'd1);

        n_exp = is_rd ? 512 : 0;
        check({name, ".strobe_count"}, 64'(strobe_q.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < strobe_q.size(); i++)
            check($sformatf("%s.strobe[%0d]", name, i), 64'(strobe_q[i]),
                  64'({9'(i), oor ? 8'hE5 : mem_byte(exp_addr(drive, lba, i))}));

        n_exp = (is_rd && !oor) ? 512 : 0;
        check({name, ".mem_rd_count"}, 64'(rd_q.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < rd_q.size(); i++)
            check($sformatf("%s.rd_addr[%0d]", name, i), 64'(rd_q[i]),
                  64'(exp_addr(drive, lba, i)));

`ifdef SD_RESP_WRITE_EN
        n_exp = (!is_rd && !oor) ? 512 : 0;
`else
        n_exp = 0;
`endif
        check({name, ".mem_wr_count"}, 64'(wr_q.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < wr_q.size(); i++)
            check($sformatf("%s.wr[%0d]", name, i), 64'(wr_q[i]),
                  64'({exp_addr(drive, lba, i), core_buf[i]}));
    endtask

    initial begin
        logic [1:0]  rrd, rwr;
        logic [31:0] rlba;
        int          cyc;
        int          ns, nr;
        bus.sd_lba = 32'h0;
        bus.sd_rd  = 2'b00;
        bus.sd_wr  = 2'b00;
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset.ack",       64'(bus.sd_ack),       64'd0);
        check("reset.buff_wr",   64'(bus.sd_buff_wr),   64'd0);
        check("reset.buff_addr", 64'(bus.sd_buff_addr), 64'd0);
        check("reset.buff_dout", 64'(bus.sd_buff_dout), 64'd0);
        check("reset.mem_rd",    64'(bus.mem_rd),       64'd0);
        check("reset.mem_wr",    64'(bus.mem_wr),       64'd0);
        check("reset.mem_addr",  64'(bus.mem_addr),     64'd0);
        @(negedge clk_sys);
        reset = 1'b0;

        run_xfer("rd_d0_l3",       2'b01, 2'b00, 32'd3);
        run_xfer("rd_d1_l0",       2'b10, 2'b00, 32'd0);
        run_xfer("prio_both_rd",   2'b11, 2'b11, 32'd7);
        run_xfer("prio_rd1_vs_wr", 2'b10, 2'b01, 32'd9);
        run_xfer("rd_last_in",     2'b01, 2'b00, 32'd1599);
        run_xfer("rd_oor_1600",    2'b01, 2'b00, 32'd1600);
        run_xfer("rd_oor_max",     2'b10, 2'b00, 32'hFFFF_FFFF);
        run_xfer("wr_d0_l2",       2'b00, 2'b01, 32'd2);
        run_xfer("wr_prio_d0",     2'b00, 2'b11, 32'd11);
        run_xfer("wr_oor",         2'b00, 2'b10, 32'd1600);

        max_delay = 7;
        for (int k = 0; k < 4; k++) begin
            do begin
                rrd = 2'($urandom);
                rwr = 2'($urandom);
            end while (rrd == 2'b00 && rwr == 2'b00);
            rlba = ($urandom_range(9, 0) == 0) ? 32'(1600 + $urandom_range(100, 0))
                                               : 32'($urandom_range(1599, 0));
            run_xfer($sformatf("rand%0d", k), rrd, rwr, rlba);
        end

        // Reset in the middle of a read
        max_delay = 3;
        repeat (2) @(negedge clk_sys);
        strobe_q.delete();
        rd_q.delete();
        bus.sd_lba = 32'd5;
        bus.sd_rd  = 2'b01;
        @(posedge clk_sys);
        #1;
        bus.sd_rd = 2'b00;
        cyc = 0;
        while (strobe_q.size() < 200 && cyc < 5000) begin
            @(posedge clk_sys);
            #1;
            cyc++;
        end
        check("midrst.reached_200", 64'(strobe_q.size()), 64'd200);
        #2;
        reset = 1'b1;
        #1;
        check("midrst.ack",       64'(bus.sd_ack),       64'd0);
        check("midrst.buff_wr",   64'(bus.sd_buff_wr),   64'd0);
        check("midrst.buff_addr", 64'(bus.sd_buff_addr), 64'd0);
        check("midrst.mem_rd",    64'(bus.mem_rd),       64'd0);
        check("midrst.mem_addr",  64'(bus.mem_addr),     64'd0);
        ns = strobe_q.size();
        nr = rd_q.size();
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (6) @(posedge clk_sys);
        #1;
        check("midrst.no_more_strobes", 64'(strobe_q.size()), 64'(ns));
        check("midrst.no_more_mem_rd",  64'(rd_q.size()),     64'(nr));
        check("midrst.ack_idle",        64'(bus.sd_ack),      64'd0);
        run_xfer("after_rst", 2'b01, 2'b00, 32'd5);

        check("mem_req_held", 64'(hold_err), 64'd0);
        check("rd_wr_exclusive", 64'(both_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
